rr_mux_arbiter: RTL and testbench



---
 rtl/rr_mux_arbiter.sv | 126 ++++++++++++
 tb/tb_rr_mux_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arbiter
// Purpose  : Round-robin arbiter that shares one WIDTH-bit output channel
//            among INPUTS valid/ready requesters. Multi-beat packets keep the
//            grant until the in_last beat is accepted. The selected beat is
//            captured in a single registered output stage.
// Ports    : clk, rst          - clock (rising edge), synchronous active-high
//                                reset
//            in_data/in_valid/ - per-requester beat, valid and end-of-packet
//            in_last             flag
//            in_ready          - per-requester accept (one-hot or zero)
//            out_data/out_src/ - registered beat, its source index and its
//            out_last/out_valid  end-of-packet flag
//            out_ready         - downstream accept
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter #(
  parameter int WIDTH    = 8,
  parameter int INPUTS   = 4,
  parameter int SEL_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    in_data [INPUTS],
  input  logic [INPUTS-1:0]   in_valid,
  input  logic [INPUTS-1:0]   in_last,
  output logic [INPUTS-1:0]   in_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [SEL_BITS-1:0] out_src,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready
);

  // Reject configurations whose source index cannot address every requester.
  if (INPUTS < 2 || SEL_BITS < $clog2(INPUTS)) begin : g_param_check
    $error("rr_mux_arbiter: INPUTS must be >= 2 and SEL_BITS >= $clog2(INPUTS)");
  end

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state;
  logic [SEL_BITS-1:0] ptr;
  logic [SEL_BITS-1:0] lock_idx;

  logic                load;
  logic                grant_found;
  logic [SEL_BITS-1:0] grant_idx;
  logic [SEL_BITS:0]   scan_sum;
  logic [SEL_BITS-1:0] sel;
  logic                sel_valid;
  logic                xfer;
  logic [SEL_BITS-1:0] ptr_next;

  // The output register can take a new beat when empty or being drained.
  assign load = !out_valid || out_ready;

  // Rotating priority scan starting at ptr. The candidate index is formed
  // with one extra bit so the wrap works for non-power-of-2 INPUTS.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    for (int i = 0; i < INPUTS; i++) begin
      scan_sum = {1'b0, ptr} + (SEL_BITS+1)'(i);
      if (scan_sum >= (SEL_BITS+1)'(INPUTS)) begin
        scan_sum = scan_sum - (SEL_BITS+1)'(INPUTS);
      end
      if (!grant_found && in_valid[scan_sum[SEL_BITS-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_sum[SEL_BITS-1:0];
      end
    end
  end

  // While locked only the packet owner is considered, even if it is idle.
  assign sel       = (state == LOCKED) ? lock_idx : grant_idx;
  assign sel_valid = (state == LOCKED) ? in_valid[lock_idx] : grant_found;

  always_comb begin
    in_ready = '0;
    if (!rst && load && (state == LOCKED || grant_found)) begin
      in_ready = {{(INPUTS-1){1'b0}}, 1'b1} << sel;
    end
  end

  assign xfer = !rst && load && sel_valid;

  // Pointer moves to the requester after the one that just finished a packet.
  assign ptr_next = (sel == SEL_BITS'(INPUTS-1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      ptr       <= '0;
      lock_idx  <= '0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (xfer) begin
        out_data  <= in_data[sel];
        out_src   <= sel;
        out_last  <= in_last[sel];
        out_valid <= 1'b1;
        if (in_last[sel]) begin
          state <= ARB;
          ptr   <= ptr_next;
        end else begin
          state    <= LOCKED;
          lock_idx <= sel;
        end
      end else if (out_ready) begin
        // Drain: payload fields hold, only the valid flag drops.
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_arbiter
// Purpose  : Directed self-checking bench for rr_mux_arbiter. A 4-input
//            instance covers reset, round-robin order, packet lock, lock
//            with valid dropout, backpressure and reset mid-packet; a
//            3-input instance covers pointer wrap with sparse requests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter;

  logic       clk;
  logic       rst;

  // 4-input instance
  logic [7:0] d [4];
  logic [3:0] v;
  logic [3:0] l;
  logic [3:0] rdy;
  logic [7:0] odata;
  logic [1:0] osrc;
  logic       olast;
  logic       ovalid;
  logic       ordy;

  // 3-input instance
  logic [7:0] d3 [3];
  logic [2:0] v3;
  logic [2:0] l3;
  logic [2:0] rdy3;
  logic [7:0] odata3;
  logic [1:0] osrc3;
  logic       olast3;
  logic       ovalid3;
  logic       ordy3;

  int checks = 0;
  int errors = 0;

  rr_mux_arbiter #(.WIDTH(8), .INPUTS(4), .SEL_BITS(2)) u_dut (
    .clk(clk), .rst(rst),
    .in_data(d), .in_valid(v), .in_last(l), .in_ready(rdy),
    .out_data(odata), .out_src(osrc), .out_last(olast),
    .out_valid(ovalid), .out_ready(ordy)
  );

  rr_mux_arbiter #(.WIDTH(8), .INPUTS(3), .SEL_BITS(2)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_data(d3), .in_valid(v3), .in_last(l3), .in_ready(rdy3),
    .out_data(odata3), .out_src(osrc3), .out_last(olast3),
    .out_valid(ovalid3), .out_ready(ordy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst  = 1'b1;
    ordy = 1'b1;
    v    = 4'hF;
    l    = 4'hF;
    for (int i = 0; i < 4; i++) d[i] = 8'h10 + 8'(i);
    ordy3 = 1'b1;
    v3    = 3'b000;
    l3    = 3'b111;
    for (int i = 0; i < 3; i++) d3[i] = 8'h50 + 8'(i);

    // Reset with all requesters valid
    tick();
    tick();
    check("rst_in_ready", 32'(rdy), 32'h0);
    check("rst_out_valid", 32'(ovalid), 32'h0);
    check("rst_out_data", 32'(odata), 32'h0);
    check("rst_out_src", 32'(osrc), 32'h0);
    check("rst_out_last", 32'(olast), 32'h0);
    rst = 1'b0;
    #1;
    check("first_grant", 32'(rdy), 32'h1);

    // Round-robin with single-beat packets: 0,1,2,3,0,1
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr_valid", 32'(ovalid), 32'h1);
      check("rr_src", 32'(osrc), 32'(k % 4));
      check("rr_data", 32'(odata), 32'h10 + 32'(k % 4));
    end
    v = 4'h0;
    tick();
    check("drain_valid", 32'(ovalid), 32'h0);
    check("drain_data_hold", 32'(odata), 32'h11);
    check("drain_src_hold", 32'(osrc), 32'h1);

    // Packet lock: requester 2 sends A0,A1,A2 while requester 1 waits (ptr=2)
    d[2] = 8'hA0;
    l    = 4'b0010;
    v    = 4'b0110;
    #1;
    check("lock_grant2", 32'(rdy), 32'h4);
    tick();
    check("lock_a0_src", 32'(osrc), 32'h2);
    check("lock_a0_data", 32'(odata), 32'hA0);
    check("lock_a0_last", 32'(olast), 32'h0);
    d[2] = 8'hA1;
    #1;
    check("lock_ready_a1", 32'(rdy), 32'h4);
    tick();
    check("lock_a1_src", 32'(osrc), 32'h2);
    check("lock_a1_data", 32'(odata), 32'hA1);
    d[2] = 8'hA2;
    l[2] = 1'b1;
    #1;
    check("lock_ready_a2", 32'(rdy), 32'h4);
    tick();
    check("lock_a2_src", 32'(osrc), 32'h2);
    check("lock_a2_data", 32'(odata), 32'hA2);
    check("lock_a2_last", 32'(olast), 32'h1);
    check("unlock_grant1", 32'(rdy), 32'h2);
    tick();
    check("unlock_src", 32'(osrc), 32'h1);
    check("unlock_data", 32'(odata), 32'h11);
    v = 4'h0;
    tick();
    check("idle_valid", 32'(ovalid), 32'h0);

    // Lock held while the owner drops valid for 4 cycles (ptr=2)
    d[2] = 8'hB0;
    l    = 4'b0010;
    v    = 4'b0110;
    tick();
    check("drop_b0_src", 32'(osrc), 32'h2);
    check("drop_b0_data", 32'(odata), 32'hB0);
    v = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drop_ready_owner", 32'(rdy), 32'h4);
      tick();
      check("drop_no_beat", 32'(ovalid), 32'h0);
    end
    d[2] = 8'hB1;
    l[2] = 1'b1;
    v    = 4'b0110;
    tick();
    check("drop_b1_src", 32'(osrc), 32'h2);
    check("drop_b1_data", 32'(odata), 32'hB1);
    check("drop_b1_last", 32'(olast), 32'h1);
    check("drop_then_grant1", 32'(rdy), 32'h2);
    tick();
    check("drop_after_src", 32'(osrc), 32'h1);
    v = 4'h0;
    tick();

    // Backpressure: one beat held for 5 cycles, next beat follows on release
    ordy = 1'b0;
    l    = 4'hF;
    d[3] = 8'h31;
    v    = 4'b1000;
    #1;
    check("bp_grant3", 32'(rdy), 32'h8);
    tick();
    check("bp_load_data", 32'(odata), 32'h31);
    check("bp_load_src", 32'(osrc), 32'h3);
    d[3] = 8'h32;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_ready_zero", 32'(rdy), 32'h0);
      check("bp_valid", 32'(ovalid), 32'h1);
      check("bp_data_stable", 32'(odata), 32'h31);
      check("bp_src_stable", 32'(osrc), 32'h3);
      tick();
    end
    ordy = 1'b1;
    #1;
    check("bp_release_ready", 32'(rdy), 32'h8);
    tick();
    check("bp_next_valid", 32'(ovalid), 32'h1);
    check("bp_next_data", 32'(odata), 32'h32);
    v = 4'h0;
    tick();
    check("bp_no_dup", 32'(ovalid), 32'h0);

    // Reset mid-packet: locked on requester 1 after two beats (ptr=0)
    d[1] = 8'h41;
    l    = 4'b1101;
    v    = 4'b0010;
    tick();
    check("mr_b0_src", 32'(osrc), 32'h1);
    check("mr_b0_data", 32'(odata), 32'h41);
    d[1] = 8'h42;
    tick();
    check("mr_b1_data", 32'(odata), 32'h42);
    rst = 1'b1;
    v   = 4'b0011;
    #1;
    check("mr_rst_ready", 32'(rdy), 32'h0);
    tick();
    check("mr_valid", 32'(ovalid), 32'h0);
    check("mr_src", 32'(osrc), 32'h0);
    rst = 1'b0;
    #1;
    check("mr_arb_grant0", 32'(rdy), 32'h1);
    tick();
    check("mr_src0", 32'(osrc), 32'h0);
    check("mr_data0", 32'(odata), 32'h10);
    v = 4'h0;
    tick();

    // 3-input instance: wrap with sparse requests
    v3 = 3'b010;
    #1;
    check("w3_grant1", 32'(rdy3), 32'h2);
    tick();
    check("w3_src1", 32'(osrc3), 32'h1);
    v3 = 3'b001;
    #1;
    check("w3_sparse_grant0", 32'(rdy3), 32'h1);
    tick();
    check("w3_src0", 32'(osrc3), 32'h0);
    check("w3_data0", 32'(odata3), 32'h50);
    v3 = 3'b111;
    #1;
    check("w3_ptr1_grant", 32'(rdy3), 32'h2);
    tick();
    check("w3_src1b", 32'(osrc3), 32'h1);
    v3 = 3'b101;
    #1;
    check("w3_grant2", 32'(rdy3), 32'h4);
    tick();
    check("w3_src2", 32'(osrc3), 32'h2);
    check("w3_data2", 32'(odata3), 32'h52);
    v3 = 3'b111;
    #1;
    check("w3_wrap_grant0", 32'(rdy3), 32'h1);
    tick();
    check("w3_wrap_src0", 32'(osrc3), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
